// File: rtl/gf_mul_16_unit_pkg.sv
// Shared field constants, element types and small GF(2^8) helpers for the
// GF(2^16) tower-field multiplier.
package gf_mul_16_unit_pkg;

  localparam logic [8:0] GF8_POLY        = 9'h11B;
  localparam logic [7:0] GF16_BETA       = 8'h20;
  localparam int         DEFAULT_LATENCY = 2;

  typedef logic [7:0]  gf8_t;
  typedef logic [15:0] gf16_t;

  // Multiply by X, folding X^8 back through the low byte of the polynomial.
  function automatic gf8_t gf8_xtime(input gf8_t a);
    return {a[6:0], 1'b0} ^ (a[7] ? GF8_POLY[7:0] : 8'h00);
  endfunction

  // GF16_BETA is X^5, so the constant multiply is five successive xtimes.
  function automatic gf8_t gf8_mul_beta(input gf8_t a);
    gf8_t t;
    t = a;
    for (int i = 0; i < 5; i++) begin
      t = gf8_xtime(t);
    end
    return t;
  endfunction

endpackage

// File: rtl/gf_mul_16_unit_mul8.sv
// Combinational GF(2^8) multiplier, shift-and-add with per-step reduction.
module gf_mul_8
  import gf_mul_16_unit_pkg::*;
(
  input  gf8_t a,
  input  gf8_t b,
  output gf8_t p
);

  gf8_t acc;
  gf8_t sh;

  // Accumulate a*X^i for every set bit i of b, keeping a*X^i reduced.
  always_comb begin
    acc = 8'h00;
    sh  = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) begin
        acc = acc ^ sh;
      end else begin
        acc = acc;
      end
      sh = gf8_xtime(sh);
    end
    p = acc;
  end

endmodule

// File: rtl/gf_mul_16_unit.sv
// Fully pipelined GF(2^16) = GF(2^8)[Z]/(Z^2+Z+0x20) multiplier with a
// valid bit travelling alongside each stage.
module gf_mul_16_unit
  import gf_mul_16_unit_pkg::*;
#(
  parameter int LATENCY = DEFAULT_LATENCY
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_start,
  input  logic [15:0] i_x,
  input  logic [15:0] i_y,
  output logic [15:0] o_o,
  output logic        o_done
);

  // Stage 1 is fixed; the remaining LATENCY-1 registers form the output chain.
  localparam int TAIL = (LATENCY < 2) ? 1 : LATENCY - 1;

  gf8_t p11, p10, p01, p00;
  gf8_t p11_r, p10_r, p01_r, p00_r;
  logic s1_vld_r;
  gf16_t comb_res;
  gf16_t res_pipe_r [TAIL];
  logic [TAIL-1:0] vld_pipe_r;

  gf_mul_8 u_m11 (.a(i_x[15:8]), .b(i_y[15:8]), .p(p11));
  gf_mul_8 u_m10 (.a(i_x[15:8]), .b(i_y[7:0]),  .p(p10));
  gf_mul_8 u_m01 (.a(i_x[7:0]),  .b(i_y[15:8]), .p(p01));
  gf_mul_8 u_m00 (.a(i_x[7:0]),  .b(i_y[7:0]),  .p(p00));

  // Sub-products are captured only for accepted operands; valid follows i_start.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      p11_r    <= 8'h00;
      p10_r    <= 8'h00;
      p01_r    <= 8'h00;
      p00_r    <= 8'h00;
      s1_vld_r <= 1'b0;
    end else begin
      s1_vld_r <= i_start;
      if (i_start) begin
        p11_r <= p11;
        p10_r <= p10;
        p01_r <= p01;
        p00_r <= p00;
      end else begin
        p11_r <= p11_r;
        p10_r <= p10_r;
        p01_r <= p01_r;
        p00_r <= p00_r;
      end
    end
  end

  // Z^2 = Z + beta: the a1b1 term lands in both coefficients.
  always_comb begin
    comb_res = {p11_r ^ p10_r ^ p01_r, p00_r ^ gf8_mul_beta(p11_r)};
  end

  // Output chain: result and valid shift together, last entry drives the ports.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < TAIL; i++) begin
        res_pipe_r[i] <= 16'h0000;
        vld_pipe_r[i] <= 1'b0;
      end
    end else begin
      res_pipe_r[0] <= comb_res;
      vld_pipe_r[0] <= s1_vld_r;
      for (int i = 1; i < TAIL; i++) begin
        res_pipe_r[i] <= res_pipe_r[i-1];
        vld_pipe_r[i] <= vld_pipe_r[i-1];
      end
    end
  end

  assign o_o    = res_pipe_r[TAIL-1];
  assign o_done = vld_pipe_r[TAIL-1];

endmodule

// File: tb/tb_gf_mul_16_unit.sv
// Self-checking bench for gf_mul_16_unit against a log/antilog-table
// tower-field reference model.
module tb_gf_mul_16_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] x, y;
  logic [15:0] o;
  logic        done;

  int tests = 0;
  int fails = 0;
  int starts = 0;
  int dones = 0;

  int exp_t [0:509];
  int log_t [0:255];
  logic [16:0] hist [$];

  always #5 clk = ~clk;

  gf_mul_16_unit #(.LATENCY(2)) dut (
    .i_clk(clk), .i_rst(rst), .i_start(start),
    .i_x(x), .i_y(y), .o_o(o), .o_done(done)
  );

  function automatic void build_tables();
    int v;
    int t;
    v = 1;
    for (int i = 0; i < 255; i++) begin
      exp_t[i]       = v;
      exp_t[i + 255] = v;
      log_t[v]       = i;
      t = v << 1;
      if ((t & 256) != 0) t = t ^ 32'h11B;
      v = t ^ v;
    end
    log_t[0] = 0;
  endfunction

  function automatic logic [7:0] m8(input logic [7:0] a, input logic [7:0] b);
    if (a == 8'h00 || b == 8'h00) return 8'h00;
    return 8'(exp_t[log_t[a] + log_t[b]]);
  endfunction

  function automatic logic [15:0] m16(input logic [15:0] a, input logic [15:0] b);
    logic [7:0] hh, hi, lo;
    hh = m8(a[15:8], b[15:8]);
    hi = hh ^ m8(a[15:8], b[7:0]) ^ m8(a[7:0], b[15:8]);
    lo = m8(a[7:0], b[7:0]) ^ m8(8'h20, hh);
    return {hi, lo};
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  // One clock: drive a pair, then check the output due this cycle.
  task automatic step(input string tag, input bit s, input logic [15:0] a,
                      input logic [15:0] b, input logic [15:0] expv);
    logic [16:0] e;
    start = s;
    x = a;
    y = b;
    hist.push_back({s, expv});
    if (s) starts++;
    @(posedge clk);
    @(negedge clk);
    if (done === 1'b1) dones++;
    if (hist.size() >= 2) begin
      e = hist.pop_front();
      chk({tag, " done"}, {15'd0, done}, {15'd0, e[16]});
      if (e[16]) chk({tag, " data"}, o, e[15:0]);
    end
  endtask

  task automatic restart_history();
    hist.delete();
    hist.push_back(17'h0);
  endtask

  initial begin
    logic [15:0] ra, rb;
    bit          rs;
    build_tables();
    rst   = 1'b1;
    start = 1'b0;
    x     = 16'h0000;
    y     = 16'h0000;

    // 100 ns reset with outputs held at zero throughout
    #1;
    chk("reset t0 done", {15'd0, done}, 16'h0000);
    chk("reset t0 data", o, 16'h0000);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("reset done", {15'd0, done}, 16'h0000);
      chk("reset data", o, 16'h0000);
    end
    rst = 1'b0;
    restart_history();

    // Directed single starts, constants worked by hand
    step("b*b",     1'b1, 16'h0100, 16'h0100, 16'h0120);
    step("idle",    1'b0, 16'h0000, 16'h0000, 16'h0000);
    step("idle",    1'b0, 16'h0000, 16'h0000, 16'h0000);
    step("b*b20",   1'b1, 16'h0100, 16'h0120, 16'h2120);
    step("idle",    1'b0, 16'h0000, 16'h0000, 16'h0000);
    step("idle",    1'b0, 16'h0000, 16'h0000, 16'h0000);
    step("2*80",    1'b1, 16'h0002, 16'h0080, 16'h001B);
    step("idle",    1'b0, 16'h0000, 16'h0000, 16'h0000);
    step("idle",    1'b0, 16'h0000, 16'h0000, 16'h0000);
    step("x*1",     1'b1, 16'h1234, 16'h0001, 16'h1234);
    step("idle",    1'b0, 16'h0000, 16'h0000, 16'h0000);
    step("idle",    1'b0, 16'h0000, 16'h0000, 16'h0000);
    step("x*0",     1'b1, 16'h1234, 16'h0000, 16'h0000);
    step("idle",    1'b0, 16'h0000, 16'h0000, 16'h0000);
    step("idle",    1'b0, 16'h0000, 16'h0000, 16'h0000);

    // Back-to-back burst, then idle
    step("burst0",  1'b1, 16'h2222, 16'h4444, m16(16'h2222, 16'h4444));
    step("burst1",  1'b1, 16'h3322, 16'h5566, m16(16'h3322, 16'h5566));
    step("burst2",  1'b1, 16'h1234, 16'h4321, m16(16'h1234, 16'h4321));
    step("drain",   1'b0, 16'h0000, 16'h0000, 16'h0000);
    step("drain",   1'b0, 16'h0000, 16'h0000, 16'h0000);
    step("drain",   1'b0, 16'h0000, 16'h0000, 16'h0000);

    // Commutativity: swapped operands must give the unswapped product
    step("comm0",   1'b1, 16'h4444, 16'h2222, m16(16'h2222, 16'h4444));
    step("comm1",   1'b1, 16'h5566, 16'h3322, m16(16'h3322, 16'h5566));
    step("drain",   1'b0, 16'h0000, 16'h0000, 16'h0000);
    step("drain",   1'b0, 16'h0000, 16'h0000, 16'h0000);

    // Reset in the middle of a burst
    step("rb0",     1'b1, 16'hA5A5, 16'h5A5A, m16(16'hA5A5, 16'h5A5A));
    step("rb1",     1'b1, 16'hFFFF, 16'h8001, m16(16'hFFFF, 16'h8001));
    step("rb2",     1'b1, 16'h0F0F, 16'hF0F0, m16(16'h0F0F, 16'hF0F0));
    step("rb gap",  1'b0, 16'h0000, 16'h0000, 16'h0000);
    #2 rst = 1'b1;
    #1;
    chk("async rst done", {15'd0, done}, 16'h0000);
    chk("async rst data", o, 16'h0000);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("in rst done", {15'd0, done}, 16'h0000);
    end
    rst = 1'b0;
    restart_history();
    step("post rst", 1'b1, 16'h0100, 16'h0120, 16'h2120);
    step("no ghost", 1'b0, 16'h0000, 16'h0000, 16'h0000);
    step("no ghost", 1'b0, 16'h0000, 16'h0000, 16'h0000);
    step("no ghost", 1'b0, 16'h0000, 16'h0000, 16'h0000);

    // Random operands with random gaps
    starts = 0;
    dones  = 0;
    for (int i = 0; i < 10000; i++) begin
      rs = ($urandom_range(0, 3) != 0);
      ra = 16'($urandom());
      rb = 16'($urandom());
      step("rand", rs, ra, rb, m16(ra, rb));
    end
    step("rand drain", 1'b0, 16'h0000, 16'h0000, 16'h0000);
    step("rand drain", 1'b0, 16'h0000, 16'h0000, 16'h0000);
    chk_int("done count", dones, starts);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/gf_mul_16_unit.md
GF_MUL_16_UNIT -- requirements
Module: gf_mul_16

Interface
REQ-001 The module SHALL have parameter LATENCY, default 2, giving the fixed clock cycles from a sampled i_start to the matching o_done.
REQ-002 The module SHALL have port i_clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-003 The module SHALL have port i_rst, input, 1 bit: reset, asynchronous and active-high.
REQ-004 The module SHALL have port i_start, input, 1 bit: operand-valid strobe, sampled every rising edge.
REQ-005 The module SHALL have port i_x, input, 16 bits: first operand, an element of GF(2^16).
REQ-006 The module SHALL have port i_y, input, 16 bits: second operand, an element of GF(2^16).
REQ-007 The module SHALL have port o_o, output, 16 bits: the product i_x*i_y in GF(2^16), registered.
REQ-008 The module SHALL have port o_done, output, 1 bit: result-valid strobe, one cycle per accepted i_start.

Function
REQ-009 GF(2^8) SHALL be F2[X]/(X^8+X^4+X^3+X+1), i.e. polynomial 0x11B, with bit i holding the coefficient of X^i.
REQ-010 GF(2^16) SHALL be GF(2^8)[Z]/(Z^2+Z+0x20); for a 16-bit word w, w[15:8] is the Z coefficient (a1) and w[7:0] is the constant term (a0).
REQ-011 The product SHALL be high = a1b1 ^ a1b0 ^ a0b1 and low = a0b0 ^ (0x20*a1b1), with all sub-products taken in GF(2^8).
REQ-012 The datapath SHALL be fully pipelined, accepting a new operand pair every cycle with no back-pressure and no stall.
REQ-013 When i_start is 1 at edge t, o_o SHALL hold that pair's product and o_done SHALL be 1 during the cycle after edge t+LATENCY-1, i.e. exactly LATENCY edges after sampling.
REQ-014 Operand pairs started on consecutive cycles SHALL produce results on consecutive cycles, in issue order.
REQ-015 When o_done is 0, o_o SHALL be don't-care for consumers, but it SHALL be deterministic, equal to the pipeline content.
REQ-016 i_x and i_y SHALL only be consumed on cycles where i_start is 1; a valid bit SHALL travel with each pipeline stage.
REQ-017 Multiplication by 0x0000 SHALL yield 0x0000, and by 0x0001 SHALL yield the other operand.

Reset
REQ-018 While i_rst is 1, all pipeline registers, valid bits, o_o and o_done SHALL be 0, and this SHALL take effect immediately, without waiting for a clock edge.
REQ-019 Asserting i_rst mid-operation SHALL discard all in-flight operations, so that no o_done is produced for pairs started before the reset.
REQ-020 An i_start sampled on the first edge after i_rst deasserts SHALL be accepted normally.

Structure
REQ-021 A shared package SHALL hold: GF8_POLY = 0x11B, GF16_BETA = 0x20, the default LATENCY, and 8-bit and 16-bit element typedefs.
REQ-022 A combinational sub-module gf_mul_8 SHALL compute the 8x8 GF(2^8) product, instantiated 4 times (a1b1, a1b0, a0b1, a0b0), plus a constant multiply by 0x20.
REQ-023 Register placement SHALL be: stage 1 registers the four sub-products and the valid bit; stage 2 combines them and registers o_o and o_done.

Verification
REQ-024 The bench SHALL apply a reset of 100 ns with i_start=0 and require o_done=0 and o_o=0x0000 throughout.
REQ-025 The bench SHALL apply single starts and require: 0x0100*0x0100 -> 0x0120; 0x0100*0x0120 -> 0x2120; 0x0002*0x0080 -> 0x001B; 0x1234*0x0001 -> 0x1234; 0x1234*0x0000 -> 0x0000; each with o_done exactly 2 cycles later.
REQ-026 The bench SHALL issue back-to-back starts on three consecutive cycles, (0x2222,0x4444), (0x3322,0x5566), (0x1234,0x4321), then drop i_start; it SHALL require three consecutive o_done pulses, in order, each matching a software tower-field model, followed by o_done=0.
REQ-027 The bench SHALL check commutativity: 0x2222*0x4444 SHALL equal 0x4444*0x2222, and 0x3322*0x5566 SHALL equal 0x5566*0x3322.
REQ-028 The bench SHALL assert i_rst one cycle after a burst of starts and require o_done to fall immediately and no result to emerge afterwards; a start after release SHALL produce a normal result.
REQ-029 The bench SHALL run 10,000 random operand pairs with random i_start gaps, requiring every output to match the reference model and the o_done count to equal the start count.
